// File: rtl/raisin64_pkg.sv
// Shared definitions for the Raisin64 instruction fetch unit: datapath widths,
// PC stepping constants, the fetch state encoding and the buffered entry layout.
package raisin64_pkg;

    localparam int XLEN       = 64;
    localparam int INST_BYTES = 8;

    // Sequential fetch step and the mask that forces 8-byte alignment.
    localparam logic [XLEN-1:0] PC_INC        = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // One buffered instruction: the word returned by imem and the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/raisin64_fetch_fifo.sv
// Instruction buffer for the fetch unit: DEPTH entries of {data, pc} with
// push, pop, synchronous clear, occupancy count and registered head outputs.
// Push and pop may occur together at any occupancy, including full.
module raisin64_fetch_fifo
    import raisin64_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [XLEN-1:0]        i_push_data,
    input  logic [XLEN-1:0]        i_push_pc,
    input  logic                   i_pop,
    input  logic                   i_clear,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_valid,
    output logic [XLEN-1:0]        o_data,
    output logic [XLEN-1:0]        o_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    fetch_entry_t  r_head;
    logic          r_head_valid;

    fetch_entry_t  w_push_entry;
    logic          w_do_push;
    logic          w_do_pop;
    logic [PW-1:0] w_rd_next;
    logic [CW-1:0] w_count_next;

    // Resolve this cycle's push/pop and the resulting read pointer and occupancy
    always_comb begin
        w_push_entry = '{data: i_push_data, pc: i_push_pc};
        w_do_pop     = i_pop && (r_count != '0);
        w_do_push    = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);
        w_rd_next    = w_do_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
        w_count_next = r_count + CW'(w_do_push) - CW'(w_do_pop);
    end

    // Entry storage write port
    // NOTE: the storage array is deliberately not reset; r_count says which
    // entries are live, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // Pointers, occupancy and the registered head entry
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
            r_head       <= '0;
        end else if (i_clear) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_rd_ptr     <= w_rd_next;
            r_count      <= w_count_next;
            r_head_valid <= (w_count_next != '0);
            if (w_count_next != '0) begin
                // The entry being written becomes the head when the buffer
                // would otherwise be empty; bypass it straight to the head.
                r_head <= (w_do_push && (w_rd_next == r_wr_ptr)) ? w_push_entry
                                                                  : r_mem[w_rd_next];
            end
        end
    end

    assign o_count = r_count;
    assign o_valid = r_head_valid;
    assign o_data  = r_head.data;
    assign o_pc    = r_head.pc;

endmodule

// File: rtl/raisin64_fetch.sv
// Raisin64 instruction fetch unit. Issues sequential 8-byte-aligned fetches,
// pairs in-order imem responses with their PCs, buffers them and hands one
// word per cycle to decode. A redirect flushes the buffer and discards any
// responses still in flight.
// Optional build macro RAISIN64_FETCH_STATS_EN adds the stat_bubbles counter.
module raisin64_fetch
    import raisin64_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    output logic        imem_addr_valid,
    input  logic [63:0] imem_data,
    input  logic        imem_data_valid,
    input  logic        halt,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] inst_data,
    output logic [63:0] inst_pc,
    output logic        inst_valid,
`ifdef RAISIN64_FETCH_STATS_EN
    output logic [31:0] stat_bubbles,
`endif
    input  logic        inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [63:0]   r_fetch_pc;
    logic [63:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic [CW-1:0] w_fifo_count;
    logic [CW:0]   w_inflight;
    logic          w_issue;
    logic          w_resp_drop;
    logic          w_resp_push;
    logic          w_pop;
    logic [CW-1:0] w_discard_next;
    logic [CW-1:0] w_outstanding_next;
    logic [63:0]   w_redirect_pc;

    // Fetch state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Classify the incoming response and compute next request/discard counts
    always_comb begin
        w_redirect_pc = redirect_pc & PC_ALIGN_MASK;
        // In a redirect cycle any arriving response belongs to the old stream.
        w_resp_drop   = imem_data_valid &&
                        ((r_discard != '0) || (redirect && (r_outstanding != '0)));
        w_resp_push   = imem_data_valid && !redirect &&
                        (r_discard == '0) && (r_outstanding != '0);
        w_pop         = inst_valid && inst_ready && !redirect;
        if (redirect) begin
            w_discard_next     = r_outstanding + r_discard - CW'(w_resp_drop);
            w_outstanding_next = '0;
        end else begin
            w_discard_next     = r_discard - CW'(w_resp_drop);
            w_outstanding_next = r_outstanding + CW'(w_issue) - CW'(w_resp_push);
        end
    end

    // Next-state logic: one idle cycle after reset, flush while stale responses remain
    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH:   if (redirect && (w_discard_next != '0)) w_state_next = FLUSH;
            FLUSH:   if (w_discard_next == '0) w_state_next = FETCH;
            default: w_state_next = IDLE;
        endcase
    end

    // Request strobe: issue only when the buffer plus in-flight requests have room
    always_comb begin
        w_inflight      = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
        imem_addr       = r_fetch_pc;
        imem_addr_valid = (r_state == FETCH) && !halt && !redirect &&
                          (w_inflight < (CW+1)'(DEPTH));
        w_issue         = imem_addr_valid;
    end

    // Fetch/response PCs and request bookkeeping; redirect overrides sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            r_discard     <= w_discard_next;
            if (redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
            end else begin
                if (w_issue)     r_fetch_pc <= r_fetch_pc + PC_INC;
                if (w_resp_push) r_resp_pc  <= r_resp_pc + PC_INC;
            end
        end
    end

    raisin64_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_resp_push),
        .i_push_data (imem_data),
        .i_push_pc   (r_resp_pc),
        .i_pop       (w_pop),
        .i_clear     (redirect),
        .o_count     (w_fifo_count),
        .o_valid     (inst_valid),
        .o_data      (inst_data),
        .o_pc        (inst_pc)
    );

`ifdef RAISIN64_FETCH_STATS_EN
    logic [31:0] r_stat_bubbles;

    // Count cycles where decode is starved while fetch is live and not halted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_bubbles <= '0;
        end else if (!inst_valid && (r_state != IDLE) && !halt &&
                     (r_stat_bubbles != 32'hFFFF_FFFF)) begin
            r_stat_bubbles <= r_stat_bubbles + 32'd1;
        end
    end

    assign stat_bubbles = r_stat_bubbles;
`endif

endmodule

// File: tb/tb_raisin64_fetch.sv
// Self-checking bench for raisin64_fetch. A behavioural memory returns
// in-order responses with optional random stalls; a stream-level model
// predicts which requests should be issued and which PC/data pairs decode
// must see, and which responses belong to a stream killed by a redirect.
module tb_raisin64_fetch;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_addr;
    logic        imem_addr_valid;
    logic [63:0] imem_data;
    logic        imem_data_valid;
    logic        halt;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
`ifdef RAISIN64_FETCH_STATS_EN
    logic [31:0] stat_bubbles;
`endif

    raisin64_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_addr_valid (imem_addr_valid),
        .imem_data       (imem_data),
        .imem_data_valid (imem_data_valid),
        .halt            (halt),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
`ifdef RAISIN64_FETCH_STATS_EN
        .stat_bubbles    (stat_bubbles),
`endif
        .inst_ready      (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        bit          stale;
    } req_t;

    int          checks = 0;
    int          errors = 0;

    // Reference model state
    req_t        mem_q[$];      // requests accepted by memory, not yet answered
    bit          cur_v;         // a response is being presented this cycle
    req_t        cur;
    int          buffered;      // words delivered to the unit and not yet consumed
    logic [63:0] exp_req_pc;    // next address the unit should request
    logic [63:0] exp_pop_pc;    // next PC decode should receive
    int          since_reset;
    bit          mem_hold;
    int          mem_stall_pct;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check/update the model at the falling edge, then pick
    // the memory response presented in the following cycle.
    task automatic cycle();
        int stale_n;
        int live_n;
        bit exp_issue;
        @(negedge clk);
        if (!rst) begin
            stale_n = 0;
            live_n  = 0;
            foreach (mem_q[i]) begin
                if (mem_q[i].stale) stale_n++;
                else                live_n++;
            end
            if (cur_v) begin
                if (cur.stale) stale_n++;
                else           live_n++;
            end
            exp_issue = (since_reset >= 1) && (stale_n == 0) && !halt && !redirect &&
                        ((live_n + buffered) < DEPTH);
            check("inst_valid", 64'(inst_valid), 64'(buffered != 0));
            check("imem_addr_valid", 64'(imem_addr_valid), 64'(exp_issue));
            if (imem_addr_valid) begin
                check("imem_addr", imem_addr, exp_req_pc);
                mem_q.push_back('{addr: imem_addr, stale: 1'b0});
                exp_req_pc = exp_req_pc + 64'd8;
            end
            if (inst_valid && inst_ready && !redirect) begin
                check("inst_pc", inst_pc, exp_pop_pc);
                check("inst_data", inst_data, mem_word(exp_pop_pc));
                exp_pop_pc = exp_pop_pc + 64'd8;
                if (buffered > 0) buffered--;
            end
            if (redirect) begin
                buffered = 0;
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                exp_req_pc = redirect_pc & ~64'h7;
                exp_pop_pc = redirect_pc & ~64'h7;
            end else if (cur_v && !cur.stale) begin
                buffered++;
            end
        end
        @(posedge clk);
        if (rst) begin
            since_reset = 0;
            mem_q.delete();
        end else begin
            since_reset++;
        end
        #1;
        cur_v = 1'b0;
        if (!rst && (mem_q.size() > 0) && !mem_hold &&
            ($urandom_range(99) >= 32'(mem_stall_pct))) begin
            cur   = mem_q.pop_front();
            cur_v = 1'b1;
        end
        imem_data_valid = cur_v;
        imem_data       = cur_v ? mem_word(cur.addr) : {$urandom, $urandom};
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        halt     = 1'b0;
        cycle();
        cycle();
        check("rst_addr_valid", 64'(imem_addr_valid), 64'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst_data", inst_data, 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
        buffered   = 0;
        exp_req_pc = RESET_PC;
        exp_pop_pc = RESET_PC;
        rst        = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        halt            = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        inst_ready      = 1'b1;
        imem_data       = '0;
        imem_data_valid = 1'b0;
        cur_v           = 1'b0;
        buffered        = 0;
        since_reset     = 0;
        mem_hold        = 1'b0;
        mem_stall_pct   = 0;
        exp_req_pc      = RESET_PC;
        exp_pop_pc      = RESET_PC;

        // Reset release with a 1-cycle memory: first word reaches decode in cycle 3
        do_reset();
        repeat (3) cycle();
        check("first_valid", 64'(inst_valid), 64'd1);
        check("first_pc", inst_pc, RESET_PC);
        check("first_data", inst_data, mem_word(RESET_PC));
`ifdef RAISIN64_FETCH_STATS_EN
        check("stat_bubbles", 64'(stat_bubbles), 64'd2);
`endif
        repeat (6) cycle();

        // Decode back-pressure: issue must cap at DEPTH, then drain in order
        inst_ready = 1'b0;
        repeat (10) cycle();
        check("stall_head_held", 64'(inst_valid), 64'd1);
        inst_ready = 1'b1;
        repeat (12) cycle();

        // Redirect with two requests outstanding
        mem_hold = 1'b1;
        for (int i = 0; i < 20 && mem_q.size() < 2; i++) cycle();
        check("two_outstanding", 64'(mem_q.size()), 64'd2);
        redirect    = 1'b1;
        redirect_pc = 64'h1004;
        cycle();
        redirect = 1'b0;
        mem_hold = 1'b0;
        repeat (10) cycle();

        // Redirect in the same cycle as a response and a pop
        for (int i = 0; i < 20 && !(cur_v && inst_valid); i++) cycle();
        check("resp_and_pop_ready", 64'(cur_v && inst_valid), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
        cycle();
        redirect = 1'b0;
        check("flush_inst_valid", 64'(inst_valid), 64'd0);
        repeat (8) cycle();

        // Halt with requests in flight
        halt = 1'b1;
        repeat (5) cycle();
        halt = 1'b0;
        repeat (8) cycle();

        // PC wrap-around at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        redirect = 1'b0;
        repeat (10) cycle();
        check("wrap_next_req", imem_addr, exp_req_pc);

        // Randomized traffic: memory stalls, back-pressure, halts, redirects
        mem_stall_pct = 30;
        for (int i = 0; i < 1500; i++) begin
            inst_ready  = ($urandom_range(3) != 0);
            halt        = ($urandom_range(7) == 0);
            redirect    = ($urandom_range(29) == 0);
            redirect_pc = {$urandom, $urandom};
            cycle();
        end
        redirect      = 1'b0;
        halt          = 1'b0;
        inst_ready    = 1'b1;
        mem_stall_pct = 0;
        repeat (20) cycle();

        // Reset in the middle of traffic, then restart cleanly
        do_reset();
        repeat (8) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
